mini68k_bus_ctrl: RTL

//  Bus interface unit between the mini68k core and the external 68000-style asynchronous bus.

---
 rtl/mini68k_bus_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mini68k_bus_ctrl.sv
// Bus interface unit: turns single valid/ready core transfers into 68000-style
// AS/UDS/LDS/DTACK bus cycles, with DTACK timeout and BR/BG/BGACK arbitration.
module mini68k_bus_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    input  logic [2:0]  req_fc,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_berr,
    output logic [23:0] addr,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        data_oe,
    output logic        bus_oe,
    output logic        as_n,
    output logic        rw,
    output logic        uds_n,
    output logic        lds_n,
    output logic [2:0]  fc,
    input  logic        dtack_n,
    input  logic        br_n,
    input  logic        bgack_n,
    output logic        bg_n
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ASSERT, S_WAIT, S_END, S_RECOV, S_BG_WAIT, S_BG_HELD
    } state_t;

    state_t state_reg, state_next;

    // Two-flop synchronisers for the asynchronous bus inputs, idle-high.
    logic [2:0] async_in;
    logic [2:0] sync_s;
    assign async_in = {bgack_n, br_n, dtack_n};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg, s2_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg <= 1'b1;
                    s2_reg <= 1'b1;
                end else begin
                    s1_reg <= async_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_s[gi] = s2_reg;
        end
    endgenerate

    logic dtack_s, br_s, bgack_s;
    assign dtack_s = sync_s[0];
    assign br_s    = sync_s[1];
    assign bgack_s = sync_s[2];

    logic [23:0]      addr_reg, addr_next;
    logic [2:0]       fc_reg, fc_next;
    logic             rw_reg, rw_next;
    logic             we_reg, we_next;
    logic [1:0]       be_reg, be_next;
    logic [15:0]      data_out_reg, data_out_next;
    logic             data_oe_reg, data_oe_next;
    logic             as_n_reg, as_n_next;
    logic             uds_n_reg, uds_n_next;
    logic             lds_n_reg, lds_n_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [15:0]      rdata_lat_reg, rdata_lat_next;
    logic             berr_lat_reg, berr_lat_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_berr_reg, rsp_berr_next;
    logic [15:0]      rsp_rdata_reg, rsp_rdata_next;

    // Bus outputs are registered and change on state transitions, so strobes
    // take effect on entry to ASSERT and release on the way out of END.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        fc_next        = fc_reg;
        rw_next        = rw_reg;
        we_next        = we_reg;
        be_next        = be_reg;
        data_out_next  = data_out_reg;
        data_oe_next   = data_oe_reg;
        as_n_next      = as_n_reg;
        uds_n_next     = uds_n_reg;
        lds_n_next     = lds_n_reg;
        cnt_next       = cnt_reg;
        rdata_lat_next = rdata_lat_reg;
        berr_lat_next  = berr_lat_reg;
        rsp_valid_next = 1'b0;
        rsp_berr_next  = 1'b0;
        rsp_rdata_next = 16'h0000;

        case (state_reg)
            S_IDLE: begin
                if (!br_s) begin
                    state_next = S_BG_WAIT;
                end else if (req_valid) begin
                    if (req_be == 2'b00) begin
                        // Nothing to strobe: answer with a bus error, no bus cycle.
                        rsp_valid_next = 1'b1;
                        rsp_berr_next  = 1'b1;
                    end else begin
                        addr_next     = req_addr & 24'hFFFFFE;
                        fc_next       = req_fc;
                        rw_next       = ~req_we;
                        we_next       = req_we;
                        be_next       = req_be;
                        data_out_next = req_wdata;
                        data_oe_next  = req_we;
                        state_next    = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                as_n_next  = 1'b0;
                uds_n_next = ~be_reg[1];
                lds_n_next = ~be_reg[0];
                cnt_next   = '0;
                state_next = S_ASSERT;
            end
            S_ASSERT: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!dtack_s) begin
                    rdata_lat_next = we_reg ? 16'h0000 : data_in;
                    berr_lat_next  = 1'b0;
                    state_next     = S_END;
                end else if (cnt_reg == CNT_LAST) begin
                    rdata_lat_next = 16'h0000;
                    berr_lat_next  = 1'b1;
                    state_next     = S_END;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_END: begin
                as_n_next      = 1'b1;
                uds_n_next     = 1'b1;
                lds_n_next     = 1'b1;
                rw_next        = 1'b1;
                data_oe_next   = 1'b0;
                rsp_valid_next = 1'b1;
                rsp_berr_next  = berr_lat_reg;
                rsp_rdata_next = rdata_lat_reg;
                state_next     = S_RECOV;
            end
            S_RECOV: begin
                // A slave that never answered will not release DTACK either.
                if (berr_lat_reg || dtack_s) begin
                    state_next = S_IDLE;
                end
            end
            S_BG_WAIT: begin
                if (!bgack_s) begin
                    state_next = S_BG_HELD;
                end else if (br_s) begin
                    state_next = S_IDLE;
                end
            end
            S_BG_HELD: begin
                data_oe_next = 1'b0;
                if (bgack_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= 24'h000000;
            fc_reg        <= 3'b000;
            rw_reg        <= 1'b1;
            we_reg        <= 1'b0;
            be_reg        <= 2'b00;
            data_out_reg  <= 16'h0000;
            data_oe_reg   <= 1'b0;
            as_n_reg      <= 1'b1;
            uds_n_reg     <= 1'b1;
            lds_n_reg     <= 1'b1;
            cnt_reg       <= '0;
            rdata_lat_reg <= 16'h0000;
            berr_lat_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_berr_reg  <= 1'b0;
            rsp_rdata_reg <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            fc_reg        <= fc_next;
            rw_reg        <= rw_next;
            we_reg        <= we_next;
            be_reg        <= be_next;
            data_out_reg  <= data_out_next;
            data_oe_reg   <= data_oe_next;
            as_n_reg      <= as_n_next;
            uds_n_reg     <= uds_n_next;
            lds_n_reg     <= lds_n_next;
            cnt_reg       <= cnt_next;
            rdata_lat_reg <= rdata_lat_next;
            berr_lat_reg  <= berr_lat_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_berr_reg  <= rsp_berr_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    assign req_ready = rst_n && (state_reg == S_IDLE) && br_s;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_berr  = rsp_berr_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign addr      = addr_reg;
    assign fc        = fc_reg;
    assign rw        = rw_reg;
    assign data_out  = data_out_reg;
    assign data_oe   = data_oe_reg;
    assign as_n      = as_n_reg;
    assign uds_n     = uds_n_reg;
    assign lds_n     = lds_n_reg;
    assign bus_oe    = (state_reg != S_BG_HELD);
    assign bg_n      = (state_reg != S_BG_WAIT);

endmodule
